// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/gnt/rvalid port and the
// valid/ready instruction hand-off to decode, plus branch inputs and fault status.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        PC_Src;
  logic [31:0] Imm_Ext;
  logic        fault;
  logic [1:0]  fault_code;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid, fault, fault_code,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, PC_Src, Imm_Ext
  );

  // Memory / decode side
  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid, fault, fault_code,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, PC_Src, Imm_Ext
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Program counter and single-outstanding instruction fetch sequencer.
// Issues one memory request at a time, hands the fetched word to decode, then
// computes the next PC on accept. Misaligned targets and memory timeouts trap
// into a sticky fault state that only reset leaves.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_1000,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  instr_fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ST_W  = 3;

  localparam logic [ST_W-1:0] S_BOOT  = 3'd0;
  localparam logic [ST_W-1:0] S_REQ   = 3'd1;
  localparam logic [ST_W-1:0] S_WAIT  = 3'd2;
  localparam logic [ST_W-1:0] S_VALID = 3'd3;
  localparam logic [ST_W-1:0] S_FAULT = 3'd4;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_MISALIGN = 2'b01;
  localparam logic [1:0] FC_TIMEOUT  = 2'b10;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [ST_W-1:0]  state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       fcode_q, fcode_d;
  logic             req_q, valid_q, fault_q;
  logic [31:0]      target;

  // Next PC for the instruction being accepted (32-bit wrap is intended)
  assign target  = bus.PC_Src ? (inst_pc_q + bus.Imm_Ext) : (inst_pc_q + 32'd4);
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    cnt_d     = cnt_q;
    fcode_d   = fcode_q;
    case (state_q)
      S_BOOT: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.imem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A response on the timeout cycle still counts as a normal fetch
        if (bus.imem_rvalid) begin
          state_d   = S_VALID;
          inst_d    = bus.imem_rdata;
          inst_pc_d = pc_q;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_d = S_FAULT;
          fcode_d = FC_TIMEOUT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_VALID: begin
        if (bus.inst_ready) begin
          // PC takes the target even when misaligned so it is visible for debug
          pc_d = target;
          if (target[1:0] != 2'b00) begin
            state_d = S_FAULT;
            fcode_d = FC_MISALIGN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and registered outputs, decoded from the upcoming state
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_VECTOR;
      inst_q    <= '0;
      inst_pc_q <= '0;
      cnt_q     <= '0;
      fcode_q   <= FC_NONE;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      cnt_q     <= cnt_d;
      fcode_q   <= fcode_d;
      req_q     <= (state_d == S_REQ);
      valid_q   <= (state_d == S_VALID);
      fault_q   <= (state_d == S_FAULT);
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = valid_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fcode_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a branch/sequence vector table,
// hand-written corner sequences, and randomized memory/decode timing checked
// against an instruction-stream model (expected PC sequence plus a memory image).
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        gnt, rvalid, ready, pc_src;
  logic [31:0] rdata, imm;
  int          total = 0;
  int          bad   = 0;

  instr_fetch_unit_if bus();
  instr_fetch_unit_if bus3();

  assign bus.imem_gnt     = gnt;
  assign bus.imem_rvalid  = rvalid;
  assign bus.imem_rdata   = rdata;
  assign bus.inst_ready   = ready;
  assign bus.PC_Src       = pc_src;
  assign bus.Imm_Ext      = imm;
  assign bus3.imem_gnt    = gnt;
  assign bus3.imem_rvalid = rvalid;
  assign bus3.imem_rdata  = rdata;
  assign bus3.inst_ready  = ready;
  assign bus3.PC_Src      = pc_src;
  assign bus3.Imm_Ext     = imm;

  instr_fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  instr_fetch_unit #(.RESET_VECTOR(RV), .TIMEOUT(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          src;
    logic [31:0] off;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[9];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0;
    pc_src = 1'b0; imm = '0; rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Wait (bounded) for a request on the main DUT
  task automatic wait_req(output int waited);
    waited = 0;
    while (bus.imem_req !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("req_seen", 32'(bus.imem_req), 32'd1);
  endtask

  // One full fetch transaction with chosen grant delay, read latency and ready delay
  task automatic fetch_one(input logic [31:0] exp_addr, input int gd, input int rl,
                           input int rd, input bit src, input logic [31:0] off,
                           input bit chk_imm);
    int          waited;
    logic [31:0] d;
    wait_req(waited);
    if (chk_imm) chk("accept_to_req", 32'(waited), 32'd0);
    chk("req_addr", bus.imem_addr, exp_addr);
    repeat (gd) begin
      @(negedge clk);
      chk("addr_hold", bus.imem_addr, exp_addr);
      chk("req_hold", 32'(bus.imem_req), 32'd1);
    end
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    chk("req_drop", 32'(bus.imem_req), 32'd0);
    repeat (rl - 1) begin
      @(negedge clk);
      chk("wait_idle", {30'd0, bus.imem_req, bus.inst_valid}, 32'd0);
    end
    d = mem_word(exp_addr);
    rvalid = 1'b1;
    rdata  = d;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = $urandom;
    chk("inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("inst", bus.inst, d);
    chk("inst_pc", bus.inst_pc, exp_addr);
    repeat (rd) begin
      rvalid = 1'($urandom);
      pc_src = 1'($urandom);
      imm    = $urandom;
      @(negedge clk);
      chk("inst_stable", bus.inst, d);
      chk("inst_pc_stable", bus.inst_pc, exp_addr);
      chk("hold_state", {30'd0, bus.imem_req, bus.inst_valid}, 32'd1);
    end
    rvalid = 1'b0;
    ready  = 1'b1;
    pc_src = src;
    imm    = off;
    @(negedge clk);
    ready  = 1'b0;
    pc_src = 1'($urandom);
    imm    = $urandom;
    chk("valid_drop", 32'(bus.inst_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int          waited;
    logic [31:0] exp_pc, nxt;
    int          gd, rl, rd, o;
    bit          src;

    tbl[0] = '{1'b0, 32'h0000_0000, 32'h0000_1000};
    tbl[1] = '{1'b0, 32'h0000_0000, 32'h0000_1004};
    tbl[2] = '{1'b1, 32'hFFFF_FFF8, 32'h0000_1008};
    tbl[3] = '{1'b0, 32'h0000_0000, 32'h0000_1000};
    tbl[4] = '{1'b0, 32'h0000_0000, 32'h0000_1004};
    tbl[5] = '{1'b1, 32'h0000_0010, 32'h0000_1008};
    tbl[6] = '{1'b1, 32'hFFFF_EFE4, 32'h0000_1018};
    tbl[7] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFC};
    tbl[8] = '{1'b1, 32'h0000_1000, 32'h0000_0000};

    // Reset values, then first request on the second cycle after release
    do_reset();
    reset = 1'b1;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_fault", {29'd0, bus.fault, bus.fault_code}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("first_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, RV);

    // Best-case stream through sequential, backward, forward and wrapping targets
    for (int i = 0; i < 9; i++)
      fetch_one(tbl[i].addr, 0, 1, 0, tbl[i].src, tbl[i].off, 1'b1);

    // Slow grant, slow response, slow consumer
    fetch_one(32'h0000_1000, 4, 3, 5, 1'b0, 32'd0, 1'b1);

    // Randomized timing against the instruction-stream model
    exp_pc = 32'h0000_1004;
    for (int n = 0; n < 30; n++) begin
      gd  = $urandom_range(0, 3);
      rl  = $urandom_range(1, 4);
      rd  = $urandom_range(0, 3);
      src = 1'($urandom);
      o   = int'($urandom_range(0, 32)) - 16;
      nxt = src ? exp_pc + 32'(o * 4) : exp_pc + 32'd4;
      fetch_one(exp_pc, gd, rl, rd, src, 32'(o * 4), 1'b1);
      exp_pc = nxt;
    end

    // Misaligned target: sticky fault, inputs ignored
    fetch_one(exp_pc, 0, 1, 0, 1'b1, 32'h0000_0006, 1'b1);
    chk("mis_fault", {29'd0, bus.fault, bus.fault_code}, 32'h5);
    for (int i = 0; i < 8; i++) begin
      gnt = 1'($urandom); rvalid = 1'($urandom); ready = 1'($urandom);
      @(negedge clk);
      chk("mis_sticky", {28'd0, bus.fault, bus.fault_code, bus.imem_req}, 32'hA);
      chk("mis_novalid", 32'(bus.inst_valid), 32'd0);
    end

    // Timeout with the default limit: 255 silent WAIT cycles
    do_reset();
    wait_req(waited);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    repeat (254) @(negedge clk);
    chk("to255_before", 32'(bus.fault), 32'd0);
    @(negedge clk);
    chk("to255_fault", {29'd0, bus.fault, bus.fault_code}, 32'h6);
    chk("to255_noreq", 32'(bus.imem_req), 32'd0);

    // Limit of 3: response on the third WAIT cycle still wins
    do_reset();
    wait_req(waited);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    repeat (2) @(negedge clk);
    rvalid = 1'b1;
    rdata  = 32'hCAFE_0013;
    @(negedge clk);
    rvalid = 1'b0;
    chk("to3_valid", 32'(bus3.inst_valid), 32'd1);
    chk("to3_nofault", {29'd0, bus3.fault, bus3.fault_code}, 32'd0);
    chk("to3_inst", bus3.inst, 32'hCAFE_0013);
    chk("to3_inst_pc", bus3.inst_pc, RV);

    // Limit of 3: three silent WAIT cycles fault
    do_reset();
    wait_req(waited);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("to3_before", 32'(bus3.fault), 32'd0);
    @(negedge clk);
    chk("to3_fault", {29'd0, bus3.fault, bus3.fault_code}, 32'h6);

    // Reset mid-WAIT with a stale response right after release
    do_reset();
    wait_req(waited);
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {30'd0, bus.imem_req, bus.inst_valid}, 32'd0);
    reset  = 1'b0;
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stale_req", 32'(bus.imem_req), 32'd1);
    chk("stale_addr", bus.imem_addr, RV);
    chk("stale_valid", 32'(bus.inst_valid), 32'd0);
    @(negedge clk);
    rvalid = 1'b0;
    chk("stale_valid2", 32'(bus.inst_valid), 32'd0);
    chk("stale_fault", {29'd0, bus.fault, bus.fault_code}, 32'd0);
    fetch_one(RV, 0, 1, 0, 1'b0, 32'd0, 1'b1);
    fetch_one(RV + 32'd4, 0, 2, 1, 1'b0, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
